// File: rtl/ex_muldiv_pkg.sv
// ============================================================================
// Module : ex_muldiv_pkg
// Brief  : Shared encodings for the EX-stage iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_muldiv_pkg;

  localparam int MD_ITER   = 32;
  localparam int MD_CNT_W  = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // MULT and DIV are the signed flavours; bit 0 clear marks them.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_if.sv
// ============================================================================
// Module : ex_muldiv_if
// Brief  : Operand/control/result bundle between ID/EX and the mul/div unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_if #(
  parameter int DATA_SIZE = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [DATA_SIZE-1:0] rs_data;
  logic [DATA_SIZE-1:0] rt_data;
  logic                 mthi;
  logic                 mtlo;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic [DATA_SIZE-1:0] hi;
  logic [DATA_SIZE-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_addsub.sv
// ============================================================================
// Module : muldiv_addsub
// Brief  : Adder/subtractor shared by the multiply and divide datapaths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_addsub #(
  parameter int WIDTH = 33
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  input  wire logic             i_sub,
  output logic      [WIDTH-1:0] o_sum,
  output logic                  o_carry
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  // Subtract as a + ~b + 1; carry-out set means no borrow (a >= b).
  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_carry = w_full[WIDTH];

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
// Module : ex_muldiv
// Brief  : 32-iteration shift-add multiply / restoring divide with HI/LO regs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  wire logic    clk,
  input  wire logic    rst,
  ex_muldiv_if.slave   bus
);

  localparam int MSB = DATA_SIZE - 1;

  md_state_e              r_state, w_state_nxt;
  logic [MD_CNT_W-1:0]    r_cnt, w_cnt_nxt;
  md_op_e                 r_op, w_op_nxt;
  logic                   r_sa, w_sa_nxt;
  logic                   r_sb, w_sb_nxt;
  logic [MSB:0]           r_b, w_b_nxt;
  logic [MSB:0]           r_acc, w_acc_nxt;
  logic [MSB:0]           r_q, w_q_nxt;
  logic [MSB:0]           r_hi, w_hi_nxt;
  logic [MSB:0]           r_lo, w_lo_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_dbz, w_dbz_nxt;

  logic                   w_is_div;
  logic                   w_in_signed;
  logic [MSB:0]           w_rs_mag, w_rt_mag;
  logic [DATA_SIZE:0]     w_as_a, w_as_sum, w_mul_sum;
  logic                   w_as_carry;
  logic [2*DATA_SIZE-1:0] w_prod;
  logic [MSB:0]           w_quo, w_rem;

  assign w_is_div    = r_op[1];
  assign w_in_signed = md_is_signed(bus.op);
  assign w_rs_mag    = (w_in_signed && bus.rs_data[MSB]) ? -bus.rs_data : bus.rs_data;
  assign w_rt_mag    = (w_in_signed && bus.rt_data[MSB]) ? -bus.rt_data : bus.rt_data;

  // Divide shifts the next dividend bit into the partial remainder before subtracting.
  assign w_as_a    = w_is_div ? {r_acc, r_q[MSB]} : {1'b0, r_acc};
  assign w_mul_sum = r_q[0] ? w_as_sum : {1'b0, r_acc};

  muldiv_addsub #(.WIDTH(DATA_SIZE + 1)) u_addsub (
    .i_a     (w_as_a),
    .i_b     ({1'b0, r_b}),
    .i_sub   (w_is_div),
    .o_sum   (w_as_sum),
    .o_carry (w_as_carry)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_q_nxt     = r_q;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = 1'b0;
    w_prod      = {r_acc, r_q};
    w_quo       = r_q;
    w_rem       = r_acc;

    if (bus.flush) begin
      w_state_nxt = MD_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (bus.start) begin
            w_op_nxt    = md_op_e'(bus.op);
            w_sa_nxt    = w_in_signed & bus.rs_data[MSB];
            w_sb_nxt    = w_in_signed & bus.rt_data[MSB];
            w_b_nxt     = w_rt_mag;
            w_q_nxt     = w_rs_mag;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = MD_RUN;
          end else begin
            if (bus.mthi) w_hi_nxt = bus.rs_data;
            if (bus.mtlo) w_lo_nxt = bus.rs_data;
          end
        end
        MD_RUN: begin
          if (w_is_div) begin
            w_acc_nxt = w_as_carry ? w_as_sum[MSB:0] : {r_acc[MSB-1:0], r_q[MSB]};
            w_q_nxt   = {r_q[MSB-1:0], w_as_carry};
          end else begin
            w_acc_nxt = w_mul_sum[DATA_SIZE:1];
            w_q_nxt   = {w_mul_sum[0], r_q[MSB:1]};
          end
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == MD_CNT_W'(MD_ITER - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = MD_FIX;
          end
        end
        MD_FIX: begin
          if (w_is_div) begin
            // Sign flags are only ever set for the signed ops.
            if (r_sa ^ r_sb) w_quo = -r_q;
            if (r_sa)        w_rem = -r_acc;
            // With a zero divisor the remainder path has shifted the whole dividend back out.
            if (r_b == '0) begin
              w_quo     = '1;
              w_dbz_nxt = 1'b1;
            end
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quo;
          end else begin
            if (r_sa ^ r_sb) w_prod = -{r_acc, r_q};
            w_hi_nxt = w_prod[2*DATA_SIZE-1:DATA_SIZE];
            w_lo_nxt = w_prod[MSB:0];
          end
          w_done_nxt  = 1'b1;
          w_state_nxt = MD_IDLE;
        end
        default: w_state_nxt = MD_IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_op    <= MD_MULT;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_sa    <= w_sa_nxt;
      r_sb    <= w_sb_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_q     <= w_q_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign bus.busy        = (r_state != MD_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, beside the ALU and directly downstream of the ID/EX pipeline register. Takes forwarded Rs/Rt operands, runs a 32-iteration shift-add multiply or restoring divide, and holds the result in architectural HI/LO registers. `busy` feeds the hazard unit, which stalls IF/ID/EX while an operation is in flight.

## Interface
Parameters:
- data_size, 32, operand and HI/LO width; the design and tests are fixed at 32.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin operation; sampled at a clock edge.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  in  data_size  multiplicand or dividend; also MTHI/MTLO write data.
- rt_data  in  data_size  multiplier or divisor.
- mthi  in  1  write rs_data to HI.
- mtlo  in  1  write rs_data to LO.
- flush  in  1  abort any in-flight operation.
- busy  out  1  operation in flight (state != IDLE).
- done  out  1  one-cycle pulse in the cycle after HI/LO are written.
- div_by_zero  out  1  pulses with done when a DIV/DIVU had rt_data == 0.
- hi  out  data_size  HI register.
- lo  out  data_size  LO register.

## Operation
- States:
  - IDLE: accepts start and mthi/mtlo.
  - RUN: 32 iterations; 6-bit counter 0..31.
  - FIX: sign correction and HI/LO write.
- Start latching: at IDLE with start=1, latch operand magnitudes (signed ops take two's-complement abs), sign flags and op. Counter := 0, state := RUN.
- RUN, multiply: 65-bit {acc, multiplier} shift-add, one bit per edge.
- RUN, divide: restoring divide; 33-bit subtract of divisor from {rem, next dividend bit}, one quotient bit per edge.
- RUN exit: counter == 31 → FIX.
- FIX, sign rules:
  - Signed MULT: negate the 64-bit product if operand signs differ.
  - Signed DIV: negate the quotient if signs differ; remainder takes the dividend's sign.
- FIX, write: {HI,LO} := product; or LO := quotient, HI := remainder. Then done := 1, state := IDLE.
- Divide by zero (any signedness): LO = 32'hFFFFFFFF, HI = rs_data as latched; div_by_zero = 1 with done.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: honoured only in IDLE with start=0. start wins over mthi/mtlo in the same cycle. Ignored while busy; the hazard unit must stall them.
- start while busy: ignored.
- flush: any state → IDLE at the next edge. HI/LO unchanged, no done. Flush has priority over start in the same cycle.
- Reset (any time, including mid-operation): state IDLE, counter 0, HI = LO = 0, busy = 0, done = 0, div_by_zero = 0.

## Timing
- Edge E0: start sampled → busy = 1 after E0.
- Edges E1..E32: iterations. FIX is entered after E32.
- Edge E33: HI/LO written, busy = 0, done = 1. HI/LO are valid in the cycle after E33; done and div_by_zero drop after E34.
- Total latency: 34 edges from the start edge to result visible.
- A new start is accepted in the done cycle (back-to-back operations allowed).
- MTHI/MTLO: one edge; the value is visible in the next cycle.
- busy and done are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared pipeline package: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and state encodings (MD_IDLE, MD_RUN, MD_FIX).
- Sub-module `muldiv_addsub`: 33-bit adder/subtractor shared by both datapaths (add for multiply, subtract for divide). Carry-out provides the restore decision.
- ALUOp → op/start decode lives in the control unit, not here.

## Test plan
- Reset asserted mid-RUN (count 10) → all outputs 0 immediately; no done follows.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 → after 34 edges HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; MULTU on the same operands → HI = 0x00000006, LO = 0xFFFFFFEB.
- DIV rs = -7, rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU rs = 100, rt = 7 → LO = 14, HI = 2; done pulses exactly once each.
- DIVU rt = 0, rs = 0x1234 → LO = 0xFFFFFFFF, HI = 0x1234, div_by_zero = 1 with done. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- flush at iteration 20 → IDLE next edge, prior HI/LO retained, no done. start + mthi in the same IDLE cycle → mthi ignored. start during RUN → ignored.
- MTLO rs = 0xA5A5A5A5 in IDLE → lo = 0xA5A5A5A5 next cycle. Back-to-back start in the done cycle → second result after a further 34 edges.
